mem_burst_master: RTL and testbench
===================================

Name: mem_burst_master

Overview:
- Initiator-side engine driving the single-port, word-wide data memory bus: 16-bit address, 32-bit write data, write enable, and 32-bit read data with 1-cycle registered latency.
- Accepts burst commands (base address, length, direction).
- Read bursts stream out on a valid/ready port with backpressure. Write bursts are consumed from a valid/ready port.
- Sits between the matrix-multiply datapath/controller and the memory subsystem.

Parameters:
ADDR_W, 16, memory word-address width
DATA_W, 32, memory data width
LEN_W, 12, burst length field width (1..4095 words; 0 = no-op)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when both high
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  burst base word address
cmd_len  in  LEN_W  burst length in words
rd_valid  out  1  read word available
rd_ready  in  1  consumer accepts read word
rd_data  out  DATA_W  read word
rd_last  out  1  marks final word of read burst
wr_valid  in  1  write word offered
wr_ready  out  1  engine accepts write word
wr_data  in  DATA_W  write word
mem_address  out  ADDR_W  memory address
mem_data  out  DATA_W  memory write data
mem_wren  out  1  memory write enable
mem_q  in  DATA_W  memory read data, valid the cycle after the address is presented
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE, cur_addr 0, remaining 0, buffer empty, in-flight 0. All outputs 0 except cmd_ready=1.
- Reset mid-burst: aborts immediately, discards buffered and in-flight words, and no done pulse is produced.
- States: IDLE, READ, DRAIN, WRITE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_len=0: stay in IDLE; done pulses next cycle.
  - Otherwise latch cur_addr=cmd_addr and remaining=cmd_len, then go to READ (cmd_write=0) or WRITE (cmd_write=1).
- Outside IDLE: cmd_ready=0 and cmd_valid is ignored.
- mem_address = cur_addr (registered) at all times. mem_data = wr_data (combinational).
- READ:
  - Issue a read in a cycle when (buf_count + inflight − pop) < 2, where pop = rd_valid & rd_ready. mem_wren=0.
  - On issue: cur_addr+1, remaining−1, inflight=1 for the next cycle. mem_q is captured into the 2-entry output FIFO at the end of that next cycle.
  - After the last issue, go to DRAIN.
- DRAIN: return to IDLE when the FIFO is empty and inflight=0. done pulses in the cycle after the final rd handshake.
- Read latency: cmd handshake in cycle 0, first address in cycle 1, mem_q valid in cycle 2, rd_valid first high in cycle 3.
- Read throughput: with rd_ready held high, one word per cycle sustained.
- Read backpressure: rd_ready low never loses data. Issue stalls when FIFO+inflight reaches 2.
- rd_data and rd_last are stable while rd_valid=1 and rd_ready=0. rd_last=1 only on the final word of the burst.
- WRITE:
  - wr_ready=1.
  - mem_wren = wr_valid & wr_ready (combinational), writing wr_data to cur_addr in the same cycle.
  - Each handshake: cur_addr+1, remaining−1.
  - After the final handshake, go to IDLE; done pulses next cycle.
- Address arithmetic: ADDR_W-bit modulo; 0xFFFF+1 wraps to 0x0000 with no error.
- busy = (state != IDLE).
- done is registered and high exactly 1 cycle per command, including len=0.

Test Plan:
- Memory model is a registered 1-cycle RAM with mem[a] = a*3.
- Read, rd_ready always 1: cmd addr=0x0010, len=4 -> rd_data 0x30, 0x33, 0x36, 0x39 on consecutive cycles starting cycle 3; rd_last only on 0x39; done 1 cycle after last; busy low afterwards.
- Read with backpressure: len=8, rd_ready toggled 1,0,0,1,… -> all 8 words in order with no duplicates/drops; mem_address never more than 2 ahead of the consumer.
- Write: cmd addr=0x0100, len=3, wr_data 0xA, 0xB, 0xC with wr_valid gaps -> mem_wren only in handshake cycles; mem[0x100..0x102] = A, B, C; done 1 cycle after 0xC.
- Wrap and len=0: read addr=0xFFFE, len=3 -> addresses 0xFFFE, 0xFFFF, 0x0000. A len=0 command -> done pulse with no mem access and busy stays 0.
- Reset mid-read (after 2 of 6 words): reset asserted asynchronously -> all outputs go to reset values within the same cycle; a new read cmd afterwards completes correctly with no stale words.
- Command while busy: cmd_valid held during a write burst -> cmd_ready=0 and cmd not accepted until IDLE, then accepted.

Source files
------------

// File: rtl/mem_burst_master.sv
// mem_burst_master
// Burst engine between the matrix-multiply controller and the single-port
// data memory. A command (base, length, direction) runs either a read burst,
// streamed out through a 2-entry FIFO with valid/ready backpressure, or a
// write burst, consumed word by word from a valid/ready input.
//
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   cmd_*                  burst command handshake (write, addr, len)
//   rd_valid/ready/data/last  read stream out
//   wr_valid/ready/data    write stream in
//   mem_address/data/wren  memory request side
//   mem_q                  memory read data, one cycle after the address
//   busy, done             burst in progress / one-cycle completion pulse
module mem_burst_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              done_q, done_d;
    logic              inflight_q;       // a read was issued last cycle
    logic              infl_last_q;      // ... and it was the final word
    logic [DATA_W-1:0] fifo_data_q [2];
    logic              fifo_last_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q;

    logic       pop, push, issue, wr_hs, last_rem;
    logic [2:0] occ;

    assign pop      = rd_valid & rd_ready;
    assign push     = inflight_q;
    assign last_rem = (remaining_q == LEN_W'(1));
    // Words held or on their way; a popped word frees its slot this cycle,
    // which is what sustains one word per cycle with rd_ready high.
    assign occ      = {1'b0, count_q} + {2'b00, inflight_q};
    assign issue    = (state_q == S_READ) && (occ < (3'd2 + {2'b00, pop}));
    assign wr_hs    = (state_q == S_WRITE) & wr_valid;

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign wr_ready    = (state_q == S_WRITE);
    assign mem_wren    = wr_hs;
    assign mem_address = cur_addr_q;
    assign mem_data    = wr_data;
    assign rd_valid    = (count_q != 2'd0);
    assign rd_data     = fifo_data_q[rd_ptr_q];
    assign rd_last     = rd_valid & fifo_last_q[rd_ptr_q];
    assign done        = done_q;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cur_addr_d  = cmd_addr;
                        remaining_d = cmd_len;
                        state_d     = cmd_write ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (last_rem) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Handing off the last-tagged word empties FIFO and pipe.
                if (pop && rd_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin // S_WRITE
                if (wr_hs) begin
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (last_rem) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            inflight_q  <= issue;
            infl_last_q <= issue & last_rem;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_q;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
module tb_mem_burst_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [11:0] cmd_len;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic [15:0] mem_address;
    logic [31:0] mem_data, mem_q;
    logic        mem_wren, busy, done;

    always #5 clock = ~clock;

    mem_burst_master dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .busy(busy), .done(done)
    );

    // Registered 1-cycle RAM, mem[a] = a*3 initially.
    logic [31:0] mem [0:65535];
    initial for (int a = 0; a < 65536; a++) mem[a] = 32'(a) * 32'd3;
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; logic last; } exp_t;
    exp_t sb[$];
    exp_t e_m;

    int checks = 0, failures = 0;
    int done_cnt = 0, done_cyc = -1, first_pop = -1, last_pop = -1, pops = 0;
    logic        bp_chk = 1'b0;
    logic [15:0] bp_base = '0;
    logic [15:0] ahead;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops on each read handshake.
    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bp_chk) begin
                ahead = mem_address - bp_base - 16'(pops);
                check("addr_ahead_le2", 64'(ahead <= 16'd2), 64'd1);
            end
            if (rd_valid && rd_ready) begin
                if (sb.size() == 0) begin
                    check("rd_unexpected_word", 64'd1, 64'd0);
                end else begin
                    e_m = sb.pop_front();
                    check("rd_data", 64'(rd_data), 64'(e_m.data));
                    check("rd_last", 64'(rd_last), 64'(e_m.last));
                end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pops++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_read(logic [15:0] addr, int len);
        logic [15:0] a;
        exp_t e;
        for (int i = 0; i < len; i++) begin
            a = addr + 16'(i);
            e.data = mem[a];
            e.last = (i == len - 1);
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue_cmd(logic wr, logic [15:0] addr, logic [11:0] len, output int c0);
        bit ok = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        c0 = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (cmd_ready) begin ok = 1; c0 = cyc; break; end
        end
        if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(int start_cnt, int budget);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            #1;
            if (done_cnt > start_cnt) begin ok = 1; break; end
        end
        if (!ok) check("done_timeout", 64'd0, 64'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int c0, d0;
    bit pat [4] = '{1, 0, 0, 1};
    bit wv [5] = '{0, 1, 0, 1, 1};
    logic [31:0] wd [5] = '{32'hDEAD, 32'hA, 32'hDEAD, 32'hB, 32'hC};

    initial begin
        logic [15:0] wa;
        reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        rd_ready = 0; wr_valid = 0; wr_data = '0;
        #2;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_done",      64'(done),      64'd0);
        check("rst_rd_valid",  64'(rd_valid),  64'd0);
        check("rst_wr_ready",  64'(wr_ready),  64'd0);
        check("rst_mem_wren",  64'(mem_wren),  64'd0);
        check("rst_mem_addr",  64'(mem_address), 64'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Read, rd_ready always high
        rd_ready = 1; first_pop = -1; pops = 0; d0 = done_cnt;
        push_read(16'h0010, 4);
        issue_cmd(1'b0, 16'h0010, 12'd4, c0);
        wait_done(d0, 50);
        check("rd1_first_cycle", 64'(first_pop), 64'(c0 + 3));
        check("rd1_last_cycle",  64'(last_pop),  64'(c0 + 6));
        check("rd1_done_cycle",  64'(done_cyc),  64'(c0 + 7));
        check("rd1_count",       64'(pops),      64'd4);
        check("rd1_done_once",   64'(done_cnt),  64'(d0 + 1));
        check("rd1_busy_after",  64'(busy),      64'd0);

        // Read with backpressure pattern 1,0,0,1
        rd_ready = 0; pops = 0; d0 = done_cnt; bp_base = 16'h0040;
        push_read(16'h0040, 8);
        issue_cmd(1'b0, 16'h0040, 12'd8, c0);
        bp_chk = 1'b1;
        for (int k = 0; k < 80 && done_cnt == d0; k++) begin
            rd_ready = pat[k % 4];
            tick();
        end
        bp_chk = 1'b0;
        rd_ready = 1;
        check("bp_count",     64'(pops),       64'd8);
        check("bp_sb_empty",  64'(sb.size()),  64'd0);
        check("bp_done_once", 64'(done_cnt),   64'(d0 + 1));
        tick();

        // Write with gaps
        issue_cmd(1'b1, 16'h0100, 12'd3, c0);
        wa = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            wr_valid = wv[i]; wr_data = wd[i];
            #1;
            check("wr_ready",    64'(wr_ready), 64'd1);
            check("wr_wren",     64'(mem_wren), 64'(wv[i]));
            if (wv[i]) begin
                check("wr_addr", 64'(mem_address), 64'(wa));
                wa = wa + 16'd1;
            end
            tick();
        end
        wr_valid = 0;
        check("wr_done_next",  64'(done), 64'd1);
        check("wr_busy_after", 64'(busy), 64'd0);
        check("wr_no_wren",    64'(mem_wren), 64'd0);
        tick();
        check("wr_mem100", 64'(mem[16'h0100]), 64'hA);
        check("wr_mem101", 64'(mem[16'h0101]), 64'hB);
        check("wr_mem102", 64'(mem[16'h0102]), 64'hC);
        check("wr_mem103_untouched", 64'(mem[16'h0103]), 64'(32'h0103 * 3));

        // Address wrap
        d0 = done_cnt;
        push_read(16'hFFFE, 3);
        issue_cmd(1'b0, 16'hFFFE, 12'd3, c0);
        check("wrap_a0", 64'(mem_address), 64'hFFFE);
        tick();
        check("wrap_a1", 64'(mem_address), 64'hFFFF);
        tick();
        check("wrap_a2", 64'(mem_address), 64'h0000);
        wait_done(d0, 50);
        check("wrap_sb_empty", 64'(sb.size()), 64'd0);

        // len = 0
        d0 = done_cnt;
        issue_cmd(1'b0, 16'h0055, 12'd0, c0);
        check("len0_done",  64'(done),      64'd1);
        check("len0_busy",  64'(busy),      64'd0);
        check("len0_wren",  64'(mem_wren),  64'd0);
        check("len0_ready", 64'(cmd_ready), 64'd1);
        tick();
        check("len0_done_1cyc", 64'(done),     64'd0);
        check("len0_rd_valid",  64'(rd_valid), 64'd0);
        check("len0_done_cnt",  64'(done_cnt), 64'(d0 + 1));

        // Reset mid-read after 2 of 6 words
        pops = 0;
        push_read(16'h0020, 6);
        issue_cmd(1'b0, 16'h0020, 12'd6, c0);
        for (int k = 0; k < 50 && pops < 2; k++) begin
            @(negedge clock);
            #1;
        end
        check("mid_two_words", 64'(pops), 64'd2);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_cmd_ready", 64'(cmd_ready),   64'd1);
        check("mid_rst_busy",      64'(busy),        64'd0);
        check("mid_rst_rd_valid",  64'(rd_valid),    64'd0);
        check("mid_rst_rd_last",   64'(rd_last),     64'd0);
        check("mid_rst_rd_data",   64'(rd_data),     64'd0);
        check("mid_rst_addr",      64'(mem_address), 64'd0);
        check("mid_rst_done",      64'(done),        64'd0);
        tick(); tick();
        reset = 1'b0;
        d0 = done_cnt;
        tick(); tick(); tick();
        check("mid_no_done",     64'(done_cnt), 64'(d0));
        check("mid_no_rd_valid", 64'(rd_valid), 64'd0);
        pops = 0;
        push_read(16'h0080, 2);
        issue_cmd(1'b0, 16'h0080, 12'd2, c0);
        wait_done(d0, 50);
        check("mid_new_count",   64'(pops),      64'd2);
        check("mid_new_sb",      64'(sb.size()), 64'd0);

        // Command held while busy with a write
        issue_cmd(1'b1, 16'h0300, 12'd2, c0);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0010; cmd_len = 12'd1;
        push_read(16'h0010, 1);
        pops = 0;
        wr_valid = 1; wr_data = 32'h111;
        #1;
        check("busy_cmd_ready0_a", 64'(cmd_ready), 64'd0);
        tick();
        wr_data = 32'h222;
        #1;
        check("busy_cmd_ready0_b", 64'(cmd_ready), 64'd0);
        tick();
        wr_valid = 0;
        check("busy_wr_done",      64'(done),      64'd1);
        check("busy_cmd_ready1",   64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 0;
        check("busy_accepted", 64'(busy), 64'd1);
        d0 = done_cnt;
        wait_done(d0, 50);
        check("busy_rd_count", 64'(pops), 64'd1);
        check("busy_sb_empty", 64'(sb.size()), 64'd0);
        check("busy_mem300",   64'(mem[16'h0300]), 64'h111);
        check("busy_mem301",   64'(mem[16'h0301]), 64'h222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
